// File: rtl/pulse_expander_if.sv
// Strobe-in / burst-out signal bundle for pulse_expander.
// The block driving pulse_in uses the master modport, and the expander uses the slave modport.
interface pulse_expander_if #(
  parameter int MAX_PENDING = 7
);
  localparam int PW = $clog2(MAX_PENDING + 1);

  logic          pulse_in;
  logic          level_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  modport master (
    output pulse_in,
    input  level_out,
    input  busy,
    input  pending,
    input  overflow
  );

  modport slave (
    input  pulse_in,
    output level_out,
    output busy,
    output pending,
    output overflow
  );
endinterface

// File: rtl/pulse_expander.sv
// Turns single-cycle strobes into HIGH_CYCLES-long bursts, each followed by a GAP_CYCLES low gap.
// Strobes that arrive during a burst are held in a saturating count and replayed in order.
module pulse_expander #(
  parameter int HIGH_CYCLES = 1000,
  parameter int GAP_CYCLES  = 500,
  parameter int MAX_PENDING = 7
) (
  input  logic          clock,
  input  logic          reset,
  pulse_expander_if.slave bus
);
  localparam int MAXV = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXV > 1) ? $clog2(MAXV) : 1;
  localparam int PW   = $clog2(MAX_PENDING + 1);

  localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PENDING);

  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pending_q, pending_d;
  logic          level_q, level_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;
  logic          inc, consume;

  // NOTE: every signal assigned in this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    ovf_d     = 1'b0;
    consume   = 1'b0;
    inc       = (state_q != IDLE) && bus.pulse_in;

    case (state_q)
      IDLE: begin
        if (bus.pulse_in) begin
          state_d = HIGH;
          cnt_d   = HIGH_LOAD;
        end
      end
      HIGH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (pending_q != '0 || bus.pulse_in) begin
          state_d = HIGH;
          cnt_d   = HIGH_LOAD;
          consume = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A strobe that lands on the consume edge with nothing queued is used directly.
    if (inc && !consume) begin
      if (pending_q == PEND_MAX) ovf_d = 1'b1;
      else                       pending_d = pending_q + PW'(1);
    end else if (!inc && consume) begin
      pending_d = pending_q - PW'(1);
    end

    level_d = (state_d == HIGH);
    busy_d  = (state_d != IDLE);
  end

  // NOTE: state registers use non-blocking assignments, so every register samples values from before the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= '0;
      level_q   <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      level_q   <= level_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.level_out = level_q;
  assign bus.busy      = busy_q;
  assign bus.pending   = pending_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_pulse_expander.sv
// Self-checking bench for pulse_expander: directed scenarios followed by random strobes.
// A position-in-period reference model predicts all outputs after every edge.
module tb_pulse_expander;
  localparam int H = 4;
  localparam int G = 2;
  localparam int M = 3;

  logic clock;
  logic reset;

  pulse_expander_if #(.MAX_PENDING(M)) bus ();

  pulse_expander #(
    .HIGH_CYCLES(H),
    .GAP_CYCLES (G),
    .MAX_PENDING(M)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int    total = 0;
  int    bad   = 0;
  string scn   = "init";
  int    edge_n;

  // The model tracks where the current burst is within its period, plus a count of queued events.
  bit m_active;
  int m_pos;
  int m_pend;
  bit m_ovf;

  int  rises;
  int  ovfs;
  logic prev_level;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step(input bit p, input bit r);
    bit done, take;
    if (r) begin
      m_active = 0; m_pos = 0; m_pend = 0; m_ovf = 0;
    end else begin
      m_ovf = 0;
      if (!m_active) begin
        if (p) begin m_active = 1; m_pos = 0; end
      end else begin
        done = (m_pos == H + G - 1);
        take = done && (m_pend > 0 || p);
        if (take)      m_pos = 0;
        else if (done) m_active = 0;
        else           m_pos++;
        if (p && !take) begin
          if (m_pend == M) m_ovf = 1;
          else             m_pend++;
        end else if (!p && take) begin
          m_pend--;
        end
      end
    end
  endtask

  task automatic step(input bit p, input bit r);
    reset        = r;
    bus.pulse_in = p;
    @(posedge clock);
    model_step(p, r);
    #1;
    check($sformatf("%s@%0d level", scn, edge_n), 32'(bus.level_out), 32'(m_active && m_pos < H));
    check($sformatf("%s@%0d busy", scn, edge_n), 32'(bus.busy), 32'(m_active));
    check($sformatf("%s@%0d pending", scn, edge_n), 32'(bus.pending), 32'(m_pend));
    check($sformatf("%s@%0d overflow", scn, edge_n), 32'(bus.overflow), 32'(m_ovf));
    if (bus.level_out === 1'b1 && prev_level !== 1'b1) rises++;
    if (bus.overflow === 1'b1) ovfs++;
    prev_level = bus.level_out;
  endtask

  task automatic run_scn(input string name, input logic [63:0] pmask, input int rst_edge,
                         input int len, input int exp_bursts, input int exp_ovfs);
    scn    = name;
    edge_n = 0;
    step(1'b0, 1'b1);
    rises      = 0;
    ovfs       = 0;
    prev_level = bus.level_out;
    for (int k = 1; k <= len; k++) begin
      edge_n = k;
      step(pmask[k], k == rst_edge);
    end
    check({name, " bursts"}, 32'(rises), 32'(exp_bursts));
    check({name, " overflows"}, 32'(ovfs), 32'(exp_ovfs));
  endtask

  initial begin
    logic [63:0] one;
    clock        = 1'b0;
    reset        = 1'b1;
    bus.pulse_in = 1'b0;
    one          = 64'd1;
    m_active = 0; m_pos = 0; m_pend = 0; m_ovf = 0;
    repeat (2) @(posedge clock);
    #1;

    run_scn("single", one << 10, -1, 20, 1, 0);
    run_scn("three", (one << 10) | (one << 11) | (one << 12), -1, 32, 3, 0);
    run_scn("held", (one << 10) | (one << 11) | (one << 12) | (one << 13) | (one << 14),
            -1, 40, 4, 1);
    run_scn("consume_full", (one << 10) | (one << 11) | (one << 12) | (one << 13) | (one << 16),
            -1, 44, 5, 0);
    run_scn("consume_direct", (one << 10) | (one << 16), -1, 30, 2, 0);
    run_scn("mid_reset", (one << 9) | (one << 10) | (one << 11) | (one << 20), 12, 30, 2, 0);

    scn = "random";
    step(1'b0, 1'b1);
    for (int k = 1; k <= 400; k++) begin
      edge_n = k;
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
